icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache between the instruction-fetch stage (`if_`) and the memory controller's instruction port. It serves fetch requests from a local tag/data array and, on a miss, issues one word request to the memory controller. The returned word is installed in the array and forwarded to fetch. Only RAM addresses are cached; I/O-space fetches bypass the array.

## Interface
Parameters:
- `INDEX_W`, default 8: index bits; the array holds 2^INDEX_W one-word lines.
- `ADDR_HI`, default 17: highest physical address bit used. Tag is `addr[ADDR_HI:INDEX_W+2]`.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset. Top level drives it with `rst_in | ~rdy_in`.
- `inst_req_i` in 1: fetch request from `if_`, held until `inst_done_o`.
- `inst_addr_i` in 32: fetch address, word-aligned.
- `inst_o` out 32: instruction word, valid while `inst_done_o` is high.
- `inst_done_o` out 1: one-cycle completion pulse.
- `mem_req_o` out 1: word-read request to the memory controller, held until `mem_done_i`.
- `mem_addr_o` out 32: refill address.
- `mem_inst_i` in 32: word returned by the memory controller.
- `mem_done_i` in 1: refill completion pulse from the memory controller.

## Operation
- State machine states: IDLE, REFILL, DONE.
- Reset behaviour:
  - All valid bits clear.
  - State goes to IDLE.
  - `inst_o`, `mem_addr_o` = 0; `inst_done_o`, `mem_req_o` = 0.
- IDLE, no request: outputs stay low.
- IDLE with `inst_req_i`: the request address is latched into `req_addr`.
  - Hit (valid, tags equal, not I/O): `inst_o` ← data, go to DONE.
  - Miss: set `mem_req_o`=1, `mem_addr_o`=`inst_addr_i`, go to REFILL.
- REFILL:
  - `mem_req_o` and `mem_addr_o` are held stable.
  - On `mem_done_i`: drop `mem_req_o`, latch `inst_o` ← `mem_inst_i`, go to DONE.
  - On the same edge, unless `req_addr[17:16]==2'b11`, write data/tag/valid at the index.
- DONE:
  - `inst_done_o`=1 for exactly this cycle.
  - Requests are ignored.
  - Next state is IDLE.
- I/O bypass: addresses with `[17:16]==2'b11` always miss and are never installed.
- Request withdrawn during REFILL (e.g. fetch redirected):
  - The refill still completes and the line is still installed.
  - `inst_done_o` is suppressed and the state returns directly to IDLE.
- Conflict: two addresses with the same index and different tags evict each other. There is no replacement policy beyond overwrite.
- Address bits above `ADDR_HI` are ignored.
- `mem_done_i` outside REFILL is ignored.

## Timing
- Hit: request sampled at edge t; `inst_done_o` high in cycle t+1; no `mem_req_o`.
- Miss: `mem_req_o` rises after edge t. If `mem_done_i` is seen at edge t+k, `inst_done_o` is high in cycle t+k+1.
- Throughput: at most one completion every 2 cycles.
- `rst` mid-REFILL:
  - `mem_req_o` is low the cycle after.
  - The pending line is not installed.
  - No `inst_done_o` is issued.
- Simultaneous `rst` and `mem_done_i`: reset wins.
- A write and a lookup to the same index never coincide: lookups occur only in IDLE.

## Structure
- The `INDEX_W`/`ADDR_HI` defaults and the I/O-region constant `2'b11` go in the shared defines header used by the other memory-side blocks.
- One sub-module: `icache_array`.
  - Tag/data storage plus valid flops.
  - Combinational read port: index in, tag/data/valid out.
  - One synchronous write port.
  - Synchronous valid clear on `rst`.
- FSM, hit compare and handshakes live in `icache`.

## Test plan
- Reset: hold `rst` 3 cycles.
  - All outputs are 0.
  - A request at 0x0 then misses (`mem_req_o`=1, `mem_addr_o`=0x0).
- Cold miss: request 0x0; memory returns 0x00000013 after 5 cycles. Then:
  - `inst_o`=0x00000013 with a one-cycle `inst_done_o`, 1 cycle after `mem_done_i`.
  - Re-request 0x0 gives done 1 cycle later with no `mem_req_o`.
- Conflict: fill 0x000 (0x11111111) then 0x400 (0x22222222).
  - Re-request 0x000: it misses again.
  - The refetch returns 0x11111111.
- I/O bypass: request 0x30000 twice; each raises `mem_req_o`.
- Abort: request 0x8, drop `inst_req_i` mid-REFILL, then complete `mem_done_i` with 0xDEADBEEF.
  - No `inst_done_o`.
  - A later 0x8 request hits with 0xDEADBEEF.
- Reset mid-REFILL: assert `rst` while `mem_req_o`=1.
  - `mem_req_o` is low the next cycle.
  - A later request for the same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache: default geometry,
// the I/O region code, and the controller state encoding.
package icache_pkg;

    localparam int         INDEX_W_DEF = 8;
    localparam int         ADDR_HI_DEF = 17;
    localparam logic [1:0] IO_REGION   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DONE
    } state_e;

    // The region code is the top two bits of the physical address.
    function automatic logic is_io(input logic [1:0] region);
        return region == IO_REGION;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
// The cache uses the slave view; whoever drives fetch and memory uses master.
interface icache_if;

    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_o;
    logic        inst_done_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_inst_i;
    logic        mem_done_i;

    modport slave (
        input  inst_req_i, inst_addr_i, mem_inst_i, mem_done_i,
        output inst_o, inst_done_o, mem_req_o, mem_addr_o
    );

    modport master (
        output inst_req_i, inst_addr_i, mem_inst_i, mem_done_i,
        input  inst_o, inst_done_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/data storage with per-line valid flops: one
// combinational read port and one synchronous write port.
module icache_array #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    localparam int LINES = 2 ** INDEX_W;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // NOTE: tag/data storage has no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];
    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: hit compare, refill handshake with the
// memory controller, and the IDLE/REFILL/DONE controller.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int ADDR_HI = ADDR_HI_DEF
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);

    // Line address is addr[ADDR_HI:2]; index in the low bits, tag above.
    localparam int LINE_W = ADDR_HI - 1;
    localparam int TAG_W  = LINE_W - INDEX_W;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   req_line_q, req_line_d;
    logic [31:0]         inst_q, inst_d;
    logic                inst_done_q, inst_done_d;
    logic                mem_req_q, mem_req_d;
    logic [31:0]         mem_addr_q, mem_addr_d;

    logic [LINE_W-1:0]   in_line;
    logic [TAG_W-1:0]    rd_tag;
    logic [31:0]         rd_data;
    logic                rd_valid;
    logic                hit;
    logic                we;

    assign in_line = bus.inst_addr_i[ADDR_HI:2];

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (in_line[INDEX_W-1:0]),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .we       (we),
        .wr_idx   (req_line_q[INDEX_W-1:0]),
        .wr_tag   (req_line_q[LINE_W-1:INDEX_W]),
        .wr_data  (bus.mem_inst_i)
    );

    assign hit = rd_valid && (rd_tag == in_line[LINE_W-1:INDEX_W])
              && !is_io(in_line[LINE_W-1 -: 2]);

    // I/O fetches are forwarded but never installed.
    assign we = (state_q == REFILL) && bus.mem_done_i
             && !is_io(req_line_q[LINE_W-1 -: 2]);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        req_line_d  = req_line_q;
        inst_d      = inst_q;
        inst_done_d = 1'b0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.inst_req_i) begin
                    req_line_d = in_line;
                    if (hit) begin
                        inst_d      = rd_data;
                        inst_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = bus.inst_addr_i;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                if (bus.mem_done_i) begin
                    mem_req_d = 1'b0;
                    inst_d    = bus.mem_inst_i;
                    // A withdrawn fetch still installs the line but gets no completion.
                    if (bus.inst_req_i) begin
                        inst_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_line_q  <= '0;
            inst_q      <= '0;
            inst_done_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_line_q  <= req_line_d;
            inst_q      <= inst_d;
            inst_done_q <= inst_done_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign bus.inst_o      = inst_q;
    assign bus.inst_done_o = inst_done_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fetch/memory stimulus with a scoreboard of
// expected instruction words popped on every completion pulse.
module tb_icache;

    logic clk;
    logic rst;
    icache_if bus ();

    icache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.inst_req_i = 1'b0;
        bus.mem_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst_o", bus.inst_o, 32'h0);
        check("rst_inst_done", {31'b0, bus.inst_done_o}, 32'h0);
        check("rst_mem_req", {31'b0, bus.mem_req_o}, 32'h0);
        check("rst_mem_addr", bus.mem_addr_o, 32'h0);
        rst = 1'b0;
    endtask

    // One fetch; the memory side answers lat cycles after mem_req_o is first seen.
    task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_miss,
                         input logic [31:0] data, input int lat);
        bit got = 0;
        bit saw_req = 0;
        int req_cyc = 0;
        int mdone_cyc = -1;
        int done_cyc = -1;
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = addr;
        sb.push_back(data);
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            tick();
            bus.mem_done_i = 1'b0;
            if (bus.inst_done_o) begin
                got = 1;
                done_cyc = cyc;
                bus.inst_req_i = 1'b0;
                check({tag, "_data"}, bus.inst_o, sb.pop_front());
            end else if (bus.mem_req_o) begin
                if (!saw_req) begin
                    saw_req = 1;
                    req_cyc = cyc;
                    check({tag, "_mem_addr"}, bus.mem_addr_o, addr);
                end
                if (cyc - req_cyc == lat) begin
                    bus.mem_done_i = 1'b1;
                    bus.mem_inst_i = data;
                    mdone_cyc = cyc + 1;
                end
            end
        end
        check({tag, "_completed"}, {31'b0, got}, 32'h1);
        check({tag, "_missed"}, {31'b0, saw_req}, {31'b0, exp_miss});
        check({tag, "_latency"}, done_cyc, exp_miss ? mdone_cyc : 1);
        bus.inst_req_i = 1'b0;
        tick();
        check({tag, "_done_pulse"}, {31'b0, bus.inst_done_o}, 32'h0);
    endtask

    task automatic wait_mem_req(output bit seen);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.mem_req_o) seen = 1;
        end
    endtask

    initial begin
        bit seen;
        bit spurious;
        rst = 1'b1;
        bus.inst_req_i  = 1'b0;
        bus.inst_addr_i = '0;
        bus.mem_inst_i  = '0;
        bus.mem_done_i  = 1'b0;

        // Reset, cold miss and re-hit
        do_reset();
        fetch("cold_miss", 32'h0, 1, 32'h0000_0013, 5);
        fetch("cold_hit", 32'h0, 0, 32'h0000_0013, 0);

        // Conflict on index 0; reset also clears the line filled above
        do_reset();
        fetch("fill_000", 32'h000, 1, 32'h1111_1111, 1);
        fetch("fill_400", 32'h400, 1, 32'h2222_2222, 2);
        fetch("refetch_000", 32'h000, 1, 32'h1111_1111, 1);
        fetch("refetch_400", 32'h400, 1, 32'h2222_2222, 0);

        // Bits above the tag are ignored
        fetch("alias_hi", 32'h0004_0400, 0, 32'h2222_2222, 0);

        // I/O region never installs
        fetch("io_1", 32'h0003_0000, 1, 32'hA5A5_A5A5, 1);
        fetch("io_2", 32'h0003_0000, 1, 32'h5A5A_5A5A, 2);

        // Stray mem_done_i in IDLE
        bus.mem_done_i = 1'b1;
        tick();
        bus.mem_done_i = 1'b0;
        check("stray_done", {31'b0, bus.inst_done_o}, 32'h0);
        tick();
        check("stray_done_req", {31'b0, bus.mem_req_o}, 32'h0);

        // Fetch withdrawn during refill
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h8;
        wait_mem_req(seen);
        check("abort_req_seen", {31'b0, seen}, 32'h1);
        bus.inst_req_i = 1'b0;
        tick();
        check("abort_req_held", {31'b0, bus.mem_req_o}, 32'h1);
        check("abort_addr_held", bus.mem_addr_o, 32'h8);
        bus.mem_done_i = 1'b1;
        bus.mem_inst_i = 32'hDEAD_BEEF;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.mem_done_i = 1'b0;
            if (bus.inst_done_o) spurious = 1;
        end
        check("abort_no_done", {31'b0, spurious}, 32'h0);
        check("abort_req_drop", {31'b0, bus.mem_req_o}, 32'h0);
        fetch("abort_hit", 32'h8, 0, 32'hDEAD_BEEF, 0);

        // Reset mid-refill, coinciding with mem_done_i
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'hC;
        wait_mem_req(seen);
        check("rstmid_req_seen", {31'b0, seen}, 32'h1);
        rst = 1'b1;
        bus.mem_done_i = 1'b1;
        bus.mem_inst_i = 32'h5555_5555;
        tick();
        rst = 1'b0;
        bus.mem_done_i = 1'b0;
        bus.inst_req_i = 1'b0;
        check("rstmid_req_low", {31'b0, bus.mem_req_o}, 32'h0);
        check("rstmid_no_done", {31'b0, bus.inst_done_o}, 32'h0);
        tick();
        check("rstmid_no_done2", {31'b0, bus.inst_done_o}, 32'h0);
        fetch("rstmid_refetch", 32'hC, 1, 32'h6666_6666, 1);

        check("sb_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
